edge_event_arbiter: RTL and testbench

- Collects edge events from N asynchronous level inputs and serialises them onto one shared event port with a valid/ready handshake.
- Each input goes through a synchroniser and an edge detector, then into a per-channel pending flag. A round-robin arbiter grants one pending channel at a time into a single-entry output register.
- Sits between raw external signals (buttons, strobes) and a single consumer FSM that handles one event per handshake.

---
 rtl/edge_event_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Purpose  : Collects edge events from N asynchronous level inputs and
//            serialises them onto a single valid/ready event port. Each
//            channel has a synchroniser, a history flop, an edge detector and
//            a one-deep pending flag. A round-robin arbiter moves one pending
//            event at a time into a single-entry output slot.
//
// Ports    : clk        system clock, all state on the rising edge
//            rst_n      asynchronous active-low reset
//            in         [N] asynchronous level inputs
//            ev_valid   event available in the output slot
//            ev_ready   consumer accepts the slot when ev_valid && ev_ready
//            ev_id      channel index of the presented event
//            ev_rising  1 = rising edge, 0 = falling edge
//            ev_ts      [TS_W] capture time of the event (EDGE_TIMESTAMP_EN only)
//            overflow   [N] sticky per-channel lost-event flags
//            ovf_clr    single-cycle pulse clearing all overflow flags
//
// Options  : define EDGE_TIMESTAMP_EN to add a free-running TS_W-bit counter,
//            per-channel timestamp capture and the ev_ts output port.
//
// Revision : 1.0  initial release
// ============================================================================
module edge_event_arbiter #(
   parameter int N           = 4,   // number of channels, 2..16
   parameter int SYNC_STAGES = 2,   // synchroniser depth, >= 1
   parameter int EDGE_MODE   = 2,   // 0 rising, 1 falling, 2 both
   parameter int TS_W        = 16   // timestamp width
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [$clog2(N)-1:0] ev_id,
   output logic                 ev_rising,
`ifdef EDGE_TIMESTAMP_EN
   output logic [TS_W-1:0]      ev_ts,
`endif
   output logic [N-1:0]         overflow,
   input  logic                 ovf_clr
);

   localparam int ID_W = $clog2(N);

   // -------------------------------------------------------------------------
   // Synchroniser and history
   // -------------------------------------------------------------------------
   logic [N-1:0][SYNC_STAGES-1:0] sync_q;
   logic [N-1:0]                  hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            sync_q[i][0] <= in[i];
            for (int s = 1; s < SYNC_STAGES; s++) begin
               sync_q[i][s] <= sync_q[i][s-1];
            end
            hist_q[i] <= sync_q[i][SYNC_STAGES-1];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Edge detection
   // -------------------------------------------------------------------------
   logic [N-1:0] sync_last;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] qual;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         sync_last[i] = sync_q[i][SYNC_STAGES-1];
      end
      rise = sync_last & ~hist_q;
      fall = ~sync_last & hist_q;
   end

   if (EDGE_MODE == 0) begin : g_mode_rise
      assign qual = rise;
   end else if (EDGE_MODE == 1) begin : g_mode_fall
      assign qual = fall;
   end else begin : g_mode_both
      assign qual = rise | fall;
   end

   // -------------------------------------------------------------------------
   // Round-robin grant
   // -------------------------------------------------------------------------
   logic [N-1:0]    pend_q;
   logic [N-1:0]    pend_d;
   logic [N-1:0]    pol_q;
   logic [N-1:0]    pol_d;
   logic [N-1:0]    ovf_q;
   logic [N-1:0]    ovf_d;
   logic [N-1:0]    ovf_set;
   logic [N-1:0]    capt;
   logic [N-1:0]    gnt_vec;
   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic [ID_W-1:0] gnt_id;
   logic            gnt_found;
   logic            load;
   logic            valid_q;
   logic            valid_d;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] id_d;
   logic            rising_q;
   logic            rising_d;

   // The slot takes a new event when empty or when its current event is
   // being accepted this cycle, which sustains one event per cycle.
   assign load = !valid_q || ev_ready;

   always_comb begin : arb_comb
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_vec   = '0;
      // Search starts one past the last granted channel and wraps.
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!gnt_found && pend_q[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
      if (load && gnt_found) begin
         gnt_vec[gnt_id] = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Pending flags and overflow
   // -------------------------------------------------------------------------
   always_comb begin
      pend_d  = pend_q;
      pol_d   = pol_q;
      ovf_set = '0;
      capt    = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_vec[i]) begin
            pend_d[i] = 1'b0;
         end
         if (qual[i]) begin
            // A flag being granted this cycle is free for the new edge;
            // otherwise an occupied flag keeps its old event.
            if (pend_q[i] && !gnt_vec[i]) begin
               ovf_set[i] = 1'b1;
            end else begin
               capt[i]   = 1'b1;
               pend_d[i] = 1'b1;
               pol_d[i]  = sync_last[i];
            end
         end
      end
      // A new overflow wins over a coincident clear for that bit.
      ovf_d = (ovf_q & ~{N{ovf_clr}}) | ovf_set;
   end

   // -------------------------------------------------------------------------
   // Output slot
   // -------------------------------------------------------------------------
   always_comb begin
      valid_d  = valid_q;
      id_d     = id_q;
      rising_d = rising_q;
      ptr_d    = ptr_q;
      if (load) begin
         valid_d = gnt_found;
         if (gnt_found) begin
            id_d     = gnt_id;
            rising_d = pol_q[gnt_id];
            ptr_d    = gnt_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= '0;
         pol_q    <= '0;
         ovf_q    <= '0;
         valid_q  <= 1'b0;
         id_q     <= '0;
         rising_q <= 1'b0;
         ptr_q    <= ID_W'(N - 1);
      end else begin
         pend_q   <= pend_d;
         pol_q    <= pol_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         id_q     <= id_d;
         rising_q <= rising_d;
         ptr_q    <= ptr_d;
      end
   end

   assign ev_valid  = valid_q;
   assign ev_id     = id_q;
   assign ev_rising = rising_q;
   assign overflow  = ovf_q;

   // -------------------------------------------------------------------------
   // Optional timestamps
   // -------------------------------------------------------------------------
`ifdef EDGE_TIMESTAMP_EN
   logic [TS_W-1:0]         ts_cnt_q;
   logic [N-1:0][TS_W-1:0]  pend_ts_q;
   logic [N-1:0][TS_W-1:0]  pend_ts_d;
   logic [TS_W-1:0]         ts_q;
   logic [TS_W-1:0]         ts_d;

   always_comb begin
      pend_ts_d = pend_ts_q;
      for (int i = 0; i < N; i++) begin
         if (capt[i]) begin
            pend_ts_d[i] = ts_cnt_q;
         end
      end
      ts_d = ts_q;
      if (load && gnt_found) begin
         ts_d = pend_ts_q[gnt_id];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_q  <= '0;
         pend_ts_q <= '0;
         ts_q      <= '0;
      end else begin
         ts_cnt_q  <= ts_cnt_q + 1'b1;
         pend_ts_q <= pend_ts_d;
         ts_q      <= ts_d;
      end
   end

   assign ev_ts = ts_q;
`else
   // Without timestamps TS_W sizes nothing; this empty block keeps it
   // elaborated so the parameter list is identical in both builds.
   if (TS_W < 1) begin : g_ts_w_unused
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Purpose  : Directed self-checking bench for edge_event_arbiter. Instance
//            dut_a uses both-edge mode; dut_b uses rising-only mode with an
//            8-bit timestamp so wrap can be reached quickly.
// Revision : 1.0  initial release
// ============================================================================
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [3:0] in_a = '0;
   logic       ready_a = 1'b0;
   logic       ovf_clr_a = 1'b0;
   logic       valid_a;
   logic [1:0] id_a;
   logic       rising_a;
   logic [3:0] ovf_a;

   logic [3:0] in_b = '0;
   logic       ready_b = 1'b0;
   logic       ovf_clr_b = 1'b0;
   logic       valid_b;
   logic [1:0] id_b;
   logic       rising_b;
   logic [3:0] ovf_b;

`ifdef EDGE_TIMESTAMP_EN
   logic [15:0] ts_a;
   logic [7:0]  ts_b;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int ticks    = 0;

   always #5 clk = ~clk;

   edge_event_arbiter #(.N(4), .SYNC_STAGES(2), .EDGE_MODE(2), .TS_W(16)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_a),
      .ev_valid  (valid_a),
      .ev_ready  (ready_a),
      .ev_id     (id_a),
      .ev_rising (rising_a),
`ifdef EDGE_TIMESTAMP_EN
      .ev_ts     (ts_a),
`endif
      .overflow  (ovf_a),
      .ovf_clr   (ovf_clr_a)
   );

   edge_event_arbiter #(.N(4), .SYNC_STAGES(2), .EDGE_MODE(0), .TS_W(8)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_b),
      .ev_valid  (valid_b),
      .ev_ready  (ready_b),
      .ev_id     (id_b),
      .ev_rising (rising_b),
`ifdef EDGE_TIMESTAMP_EN
      .ev_ts     (ts_b),
`endif
      .overflow  (ovf_b),
      .ovf_clr   (ovf_clr_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle; returns just after the falling edge.
   task automatic tick();
      @(negedge clk);
      ticks++;
   endtask

   task automatic wait_to(input int t);
      while (ticks < t) tick();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      ready_a   = 1'b0;
      ready_b   = 1'b0;
      ovf_clr_a = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      ticks = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      tick();
      tick();
      check_eq("rst_valid",  32'(valid_a),  32'd0);
      check_eq("rst_id",     32'(id_a),     32'd0);
      check_eq("rst_rising", 32'(rising_a), 32'd0);
      check_eq("rst_ovf",    32'(ovf_a),    32'd0);
      rst_n = 1'b1;
      ticks = 0;

      // ---------------- asynchronous reset mid-cycle ----------------
      in_a = 4'b0001;
      repeat (4) tick();
      check_eq("pre_async_valid", 32'(valid_a), 32'd1);
      check_eq("pre_async_id",    32'(id_a),    32'd0);
      #2 rst_n = 1'b0;
      #1 check_eq("async_rst_valid", 32'(valid_a), 32'd0);
      in_a = '0;
      tick();
      tick();
      rst_n = 1'b1;
      ticks = 0;

      // ---------------- single edge, latency and hold ----------------
      in_a = 4'b0010;
      repeat (3) tick();
      check_eq("lat_valid_e3", 32'(valid_a), 32'd0);
      tick();
      check_eq("lat_valid_e4", 32'(valid_a),  32'd1);
      check_eq("single_id",    32'(id_a),     32'd1);
      check_eq("single_rise",  32'(rising_a), 32'd1);
      for (int c = 0; c < 5; c++) begin
         tick();
         check_eq("hold_valid", 32'(valid_a),  32'd1);
         check_eq("hold_id",    32'(id_a),     32'd1);
         check_eq("hold_rise",  32'(rising_a), 32'd1);
      end
      ready_a = 1'b1;
      tick();
      check_eq("accept_valid", 32'(valid_a), 32'd0);
      ready_a = 1'b0;

      // ---------------- simultaneous edges ----------------
      do_reset();
      in_a    = 4'b1101;
      ready_a = 1'b1;
      repeat (4) tick();
      check_eq("sim_v0",  32'(valid_a), 32'd1);
      check_eq("sim_id0", 32'(id_a),    32'd0);
      tick();
      check_eq("sim_v1",  32'(valid_a), 32'd1);
      check_eq("sim_id1", 32'(id_a),    32'd2);
      tick();
      check_eq("sim_v2",  32'(valid_a), 32'd1);
      check_eq("sim_id2", 32'(id_a),    32'd3);
      tick();
      check_eq("sim_empty", 32'(valid_a), 32'd0);

      // ---------------- round-robin fairness ----------------
      do_reset();
      in_a = 4'b0100;
      repeat (4) tick();
      check_eq("rr_first_id", 32'(id_a), 32'd2);
      in_a = 4'b1101;
      repeat (3) tick();
      ready_a = 1'b1;
      tick();
      check_eq("rr_id3",    32'(id_a),     32'd3);
      check_eq("rr_rise3",  32'(rising_a), 32'd1);
      tick();
      check_eq("rr_id0",    32'(id_a),     32'd0);
      tick();
      check_eq("rr_empty",  32'(valid_a),  32'd0);
      ready_a = 1'b0;
      in_a = 4'b0101;
      repeat (4) tick();
      check_eq("fall_valid", 32'(valid_a),  32'd1);
      check_eq("fall_id",    32'(id_a),     32'd3);
      check_eq("fall_rise",  32'(rising_a), 32'd0);
      ready_a = 1'b1;
      tick();
      check_eq("fall_accept", 32'(valid_a), 32'd0);
      ready_a = 1'b0;

      // ---------------- overflow ----------------
      in_a = 4'b0111;                 // edge 1: rising on ch1, goes to slot
      repeat (4) tick();
      check_eq("ovf_slot_id", 32'(id_a), 32'd1);
      repeat (2) tick();
      in_a = 4'b0101;                 // edge 2: falling, stays pending
      repeat (6) tick();
      check_eq("ovf_none_yet", 32'(ovf_a), 32'd0);
      in_a = 4'b0111;                 // edge 3: overflows
      repeat (2) tick();
      check_eq("ovf_before", 32'(ovf_a), 32'd0);
      tick();
      check_eq("ovf_set",     32'(ovf_a),    32'h2);
      check_eq("ovf_hold_id", 32'(id_a),     32'd1);
      check_eq("ovf_hold_rs", 32'(rising_a), 32'd1);
      ovf_clr_a = 1'b1;
      tick();
      ovf_clr_a = 1'b0;
      check_eq("ovf_cleared", 32'(ovf_a), 32'd0);
      in_a = 4'b0101;                 // another overflow, coincident with clear
      repeat (2) tick();
      ovf_clr_a = 1'b1;
      tick();
      ovf_clr_a = 1'b0;
      check_eq("ovf_set_wins", 32'(ovf_a), 32'h2);
      ready_a = 1'b1;
      tick();
      check_eq("ovf_pend_valid", 32'(valid_a),  32'd1);
      check_eq("ovf_pend_id",    32'(id_a),     32'd1);
      check_eq("ovf_pend_pol",   32'(rising_a), 32'd0);
      tick();
      check_eq("ovf_drain", 32'(valid_a), 32'd0);
      ready_a = 1'b0;

      // ---------------- rising-only mode and timestamps ----------------
      do_reset();
      wait_to(98);
      in_b = 4'b0100;
      wait_to(101);
      check_eq("ro_early", 32'(valid_b), 32'd0);
      wait_to(102);
      check_eq("ro_valid", 32'(valid_b),  32'd1);
      check_eq("ro_id",    32'(id_b),     32'd2);
      check_eq("ro_rise",  32'(rising_b), 32'd1);
`ifdef EDGE_TIMESTAMP_EN
      check_eq("ts_100", 32'(ts_b), 32'd100);
`endif
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      check_eq("ro_accept", 32'(valid_b), 32'd0);
      in_b = 4'b0000;                 // falling edge: no event in this mode
      wait_to(109);
      check_eq("ro_no_fall", 32'(valid_b), 32'd0);
      wait_to(138);
      in_b = 4'b0100;
      wait_to(142);
      check_eq("ro_valid2", 32'(valid_b), 32'd1);
`ifdef EDGE_TIMESTAMP_EN
      check_eq("ts_140", 32'(ts_b), 32'd140);
`endif
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      in_b = 4'b0000;
      wait_to(253);
      in_b = 4'b0100;
      wait_to(257);
      check_eq("ro_valid3", 32'(valid_b), 32'd1);
`ifdef EDGE_TIMESTAMP_EN
      check_eq("ts_255", 32'(ts_b), 32'd255);
`endif
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      in_b = 4'b0000;
      wait_to(262);
      in_b = 4'b0100;
      wait_to(266);
      check_eq("ro_valid4", 32'(valid_b), 32'd1);
`ifdef EDGE_TIMESTAMP_EN
      check_eq("ts_wrap", 32'(ts_b), 32'd8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
